// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR generator and its sequence checker.
// Both sides take the polynomial from lfsr_next so they cannot drift apart.
package lfsr_pkg;

  localparam int LFSR_W = 4;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 4'hE;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQ,
    LOCKED
  } chk_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] x
  );
    return {x[2:0], x[3] ^ x[1]};
  endfunction

endpackage

// File: rtl/lfsr_seq_checker.sv
// Locks onto the upstream LFSR stream, then flags and counts every sample
// that departs from a free-running reference.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              clear_i,
  output logic              locked_o,
  output logic              err_o,
  output logic              zero_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W = $clog2(LOSS_THRESH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_THRESH);
  localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_THRESH);

  chk_state_t        r_state;
  logic [LFSR_W-1:0] r_last;
  logic [LFSR_W-1:0] r_exp;
  logic [RUN_W-1:0]  r_run;
  logic [MISS_W-1:0] r_miss;
  logic              r_locked;
  logic              r_err;
  logic              r_zero;
  logic [CNT_W-1:0]  r_cnt;

  logic [RUN_W-1:0]  w_run_inc;
  logic [MISS_W-1:0] w_miss_inc;
  logic              w_zero;
  logic              w_acq_hit;
  logic              w_lock_hit;

  assign w_run_inc  = r_run + 1'b1;
  assign w_miss_inc = r_miss + 1'b1;
  assign w_zero     = (data_i == '0);
  assign w_acq_hit  = (data_i == lfsr_next(r_last));
  assign w_lock_hit = (data_i == r_exp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= UNLOCKED;
      r_last   <= '0;
      r_exp    <= '0;
      r_run    <= '0;
      r_miss   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_zero   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_err  <= 1'b0;
      r_zero <= valid_i & w_zero;
      if (valid_i) begin
        unique case (r_state)
          UNLOCKED: begin
            if (!w_zero) begin
              r_last  <= data_i;
              r_run   <= '0;
              r_state <= ACQ;
            end
          end
          ACQ: begin
            // r_last is never zero here, so a zero sample cannot hit
            if (w_acq_hit) begin
              r_run  <= w_run_inc;
              r_last <= data_i;
              if (w_run_inc == RUN_LOCK) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_exp    <= lfsr_next(data_i);
                r_miss   <= '0;
              end
            end else if (w_zero) begin
              r_state <= UNLOCKED;
            end else begin
              r_last <= data_i;
              r_run  <= '0;
            end
          end
          LOCKED: begin
            r_exp <= lfsr_next(r_exp);
            if (w_lock_hit) begin
              r_miss <= '0;
            end else begin
              r_err  <= 1'b1;
              r_miss <= w_miss_inc;
              if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
              if (w_miss_inc == MISS_LOSS) begin
                r_state  <= UNLOCKED;
                r_locked <= 1'b0;
              end
            end
          end
          default: begin
            r_state  <= UNLOCKED;
            r_locked <= 1'b0;
          end
        endcase
      end
      // Clear wins over a same-cycle increment.
      if (clear_i) r_cnt <= '0;
    end
  end

  assign locked_o  = r_locked;
  assign err_o     = r_err;
  assign zero_o    = r_zero;
  assign err_cnt_o = r_cnt;

endmodule
